bus_mem_model: RTL and testbench
================================

Name: bus_mem_model

Overview:
Parametrised, synthesizable program/data memory responder that replaces the constant bus drive on the cpu program and data buses. It serves the cpu's instruction fetch port (ADDR_Prog/CS_P/Prog_BUS_READ) and data port (ADDR/CS/WE/Data_BUS_WRITE/Data_BUS_READ). Each channel has a configurable wait-state latency and a Ready strobe. A preload port fills program memory before the core runs. It sits beside the cpu in benches and FPGA bring-up tops.

Parameters:
DATA_W, 32, data and instruction word width in bits
ADDR_W, 32, byte-address width of both buses
PROG_DEPTH, 1024, program memory depth in words (power of 2)
DATA_DEPTH, 1024, data memory depth in words (power of 2)
RD_LAT, 1, cycles from request acceptance to Ready; legal range 1..8
IDLE_WORD, all ones, Data_BUS_READ value at reset and on out-of-range reads
NOP_WORD, 0, Prog_BUS_READ value at reset and on out-of-range fetches

Ports:
CLK  in  1  system clock; all state updates on the rising edge
Reset  in  1  asynchronous, active-low reset
ADDR_Prog  in  ADDR_W  instruction byte address
CS_P  in  1  fetch request
Prog_BUS_READ  out  DATA_W  fetched instruction
Ready_P  out  1  one-cycle pulse; Prog_BUS_READ valid
ADDR  in  ADDR_W  data byte address
CS  in  1  data request
WE  in  1  1 = write, 0 = read; sampled with CS
Data_BUS_WRITE  in  DATA_W  write data
Data_BUS_READ  out  DATA_W  read data
Ready  out  1  one-cycle pulse; data access complete
Load_EN  in  1  program preload write enable
Load_ADDR  in  clog2(PROG_DEPTH)  preload word index
Load_DATA  in  DATA_W  preload word
Addr_Err  out  1  sticky error flag; cleared only by reset
Wr_Count  out  16  count of committed data writes; saturates at 16'hFFFF

Behaviour:
- Reset asserted (low), asynchronously: Prog_BUS_READ = NOP_WORD, Data_BUS_READ = IDLE_WORD, Ready = 0, Ready_P = 0, Addr_Err = 0, Wr_Count = 0, both FSMs go to IDLE.
- Memory arrays have no reset. Contents survive a reset.
- Addressing: word index = ADDR[clog2(DEPTH)+1:2].
  - Out-of-range: any set bit of ADDR above the index field.
  - Misaligned: ADDR[1:0] != 0.
- Per-channel FSM states: IDLE, WAIT, RESP.
  - IDLE: when the request is high, latch address, WE and write data, and accept the request.
    - RD_LAT=1: go to RESP.
    - Otherwise: go to WAIT with counter = RD_LAT-2.
  - WAIT: decrement the counter; go to RESP when it reaches 0.
  - RESP: drive the output word and pulse Ready for one cycle, then return to IDLE.
  - Ready therefore rises exactly RD_LAT cycles after the accepting edge.
  - Back-to-back requests: one accepted per RD_LAT+1 cycles.
- A request held high in RESP is not re-accepted until IDLE.
- Dropping CS/CS_P in WAIT does not abort; the access completes normally.
- Data write: memory is written at the accepting edge. Wr_Count increments at the same edge. Ready still follows the latency rule. Data_BUS_READ is not changed by a write.
- Read-after-write to the same address, issued on the next request, returns the new data.
- Out-of-range or misaligned access:
  - Write is dropped and Wr_Count does not increment.
  - Read returns IDLE_WORD (data port) or NOP_WORD (program port).
  - Addr_Err is set.
  - Ready/Ready_P still pulse.
- Output words hold their last value between accesses.
- The two channels are fully independent; simultaneous CS and CS_P are both accepted in the same cycle.
- Load_EN:
  - Writes program memory at the edge.
  - While Load_EN is high, the program FSM does not accept new CS_P requests.
  - An in-flight fetch completes. If it reads a word loaded after acceptance, it returns the loaded value.
- Reset mid-transaction aborts the transaction with no Ready pulse. A write already committed at acceptance stays in memory.

Decomposition:
- Package mem_model_pkg:
  - channel state enum (IDLE/WAIT/RESP)
  - default IDLE_WORD and NOP_WORD constants
  - latency-counter width function
- Sub-module mem_lat_channel: one latency FSM with address latch, request/Ready handshake and range/alignment check, instanced twice.
  - Parameters: DEPTH, DATA_W, RD_LAT, OOR_WORD.
  - The memory array stays in the parent.

Test Plan:
- Reset low 10 ns, then release → Data_BUS_READ=32'hFFFFFFFF, Prog_BUS_READ=0, Ready/Ready_P/Addr_Err=0, Wr_Count=0.
- RD_LAT=3: preload word 4 = 32'h2008000A via Load_EN; CS_P with ADDR_Prog=32'h10 → Ready_P exactly 3 cycles after acceptance, Prog_BUS_READ=32'h2008000A.
- Write 32'hDEADBEEF to ADDR=32'h40, then read ADDR=32'h40 → read returns 32'hDEADBEEF, Wr_Count=1.
- Read ADDR=32'h1000 with DATA_DEPTH=1024 → Data_BUS_READ=32'hFFFFFFFF, Ready pulses, Addr_Err=1 and stays 1. Write to ADDR=32'h42 → Wr_Count unchanged.
- CS and CS_P raised in the same cycle, with CS dropped during WAIT → both Ready and Ready_P pulse on the same cycle with correct data.
- Reset asserted during WAIT of a read → no Ready pulse, outputs return to reset values. A following read of the previously written address returns the pre-reset contents.

Source files
------------

// File: rtl/mem_model_pkg.sv
// Shared definitions for the bus memory model.
//   ch_state_e    : per-channel latency FSM state
//   DEF_IDLE_WORD : default data-port word at reset / on bad reads (all ones)
//   DEF_NOP_WORD  : default program-port word at reset / on bad fetches (zero)
//   lat_cnt_w()   : width of the wait-state counter for a given read latency
package mem_model_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } ch_state_e;

    // Wide enough for any practical DATA_W; the top slices to size.
    localparam logic [63:0] DEF_IDLE_WORD = '1;
    localparam logic [63:0] DEF_NOP_WORD  = '0;

    // The counter holds RD_LAT-2 down to 0, so it needs clog2(RD_LAT-1) bits,
    // never fewer than one.
    function automatic int lat_cnt_w(input int rd_lat);
        return (rd_lat <= 2) ? 1 : $clog2(rd_lat - 1);
    endfunction

endpackage

// File: rtl/mem_lat_channel.sv
// One bus channel: request/Ready handshake, wait-state FSM, address latch,
// range/alignment check and the registered output word.
// The memory array lives in the parent; this block supplies the read index
// and consumes the parent's registered read data.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request strobe (CS / CS_P)
//   req_en     : gate on acceptance (program port is blocked during preload)
//   addr       : byte address of the request
//   we         : 1 = write (no output-word update), 0 = read
//   rd_word    : parent's registered read of mem[mem_idx]
//   accept     : request accepted at this edge
//   addr_bad   : live address is out of range or misaligned
//   mem_idx    : read/write word index presented to the parent's memory
//   bus_word   : output word, held between accesses
//   ready      : one-cycle completion pulse
module mem_lat_channel
    import mem_model_pkg::*;
#(
    parameter int              DEPTH    = 1024,
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 32,
    parameter int              RD_LAT   = 1,
    parameter logic [DATA_W-1:0] OOR_WORD = '0,
    localparam int             IDX_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              req_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] rd_word,
    output logic              accept,
    output logic              addr_bad,
    output logic [IDX_W-1:0]  mem_idx,
    output logic [DATA_W-1:0] bus_word,
    output logic              ready
);

    localparam int CNT_W      = lat_cnt_w(RD_LAT);
    localparam int CNT_INIT_I = (RD_LAT >= 2) ? RD_LAT - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_INIT_I[CNT_W-1:0];

    ch_state_e         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IDX_W-1:0]  idx_reg;
    logic              we_reg;
    logic              bad_reg;
    logic              ready_reg;
    logic [DATA_W-1:0] word_reg;

    logic [IDX_W-1:0]  live_idx;
    logic              live_bad;

    assign live_idx = addr[IDX_W+1:2];
    assign live_bad = (|addr[ADDR_W-1:IDX_W+2]) | (|addr[1:0]);

    // State register plus the request latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            we_reg    <= 1'b0;
            bad_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                idx_reg <= live_idx;
                we_reg  <= we;
                bad_reg <= live_bad;
            end
        end
    end

    // Next-state logic. WAIT tests the counter before decrementing so that
    // the Ready edge lands exactly RD_LAT edges after acceptance.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (RD_LAT == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Combinational outputs. While idle the memory sees the live address so
    // that a write commits at the accepting edge and, for RD_LAT=1, the read
    // is already in flight on that same edge.
    always_comb begin
        accept   = (state_reg == IDLE) && req && req_en;
        addr_bad = live_bad;
        mem_idx  = (state_reg == IDLE) ? live_idx : idx_reg;
    end

    // Registered outputs: updated on the edge that leaves RESP. rd_word was
    // captured on the edge entering RESP, so it reflects any preload or
    // write made while the access was waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg <= 1'b0;
            word_reg  <= OOR_WORD;
        end else begin
            ready_reg <= (state_reg == RESP);
            if ((state_reg == RESP) && !we_reg) begin
                word_reg <= bad_reg ? OOR_WORD : rd_word;
            end
        end
    end

    assign ready    = ready_reg;
    assign bus_word = word_reg;

endmodule

// File: rtl/bus_mem_model.sv
// Program/data memory responder for the cpu buses.
// Two independent latency channels (fetch and data) share one clock; program
// memory can be preloaded through the Load_* port.
//   CLK, Reset          : clock, asynchronous active-low reset
//   ADDR_Prog, CS_P     : fetch request;  Prog_BUS_READ, Ready_P : response
//   ADDR, CS, WE,
//   Data_BUS_WRITE      : data request;   Data_BUS_READ, Ready   : response
//   Load_EN/ADDR/DATA   : program memory preload (blocks new fetches)
//   Addr_Err            : sticky out-of-range/misaligned flag
//   Wr_Count            : saturating count of committed data writes
module bus_mem_model
    import mem_model_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                PROG_DEPTH = 1024,
    parameter int                DATA_DEPTH = 1024,
    parameter int                RD_LAT     = 1,
    parameter logic [DATA_W-1:0] IDLE_WORD  = DEF_IDLE_WORD[DATA_W-1:0],
    parameter logic [DATA_W-1:0] NOP_WORD   = DEF_NOP_WORD[DATA_W-1:0],
    localparam int               PIDX_W     = $clog2(PROG_DEPTH),
    localparam int               DIDX_W     = $clog2(DATA_DEPTH)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] ADDR_Prog,
    input  logic              CS_P,
    output logic [DATA_W-1:0] Prog_BUS_READ,
    output logic              Ready_P,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              CS,
    input  logic              WE,
    input  logic [DATA_W-1:0] Data_BUS_WRITE,
    output logic [DATA_W-1:0] Data_BUS_READ,
    output logic              Ready,
    input  logic              Load_EN,
    input  logic [PIDX_W-1:0] Load_ADDR,
    input  logic [DATA_W-1:0] Load_DATA,
    output logic              Addr_Err,
    output logic [15:0]       Wr_Count
);

    logic [DATA_W-1:0] pmem [PROG_DEPTH];
    logic [DATA_W-1:0] dmem [DATA_DEPTH];
    logic [DATA_W-1:0] pmem_q;
    logic [DATA_W-1:0] dmem_q;

    logic              p_accept, p_addr_bad;
    logic [PIDX_W-1:0] p_mem_idx;
    logic              d_accept, d_addr_bad;
    logic [DIDX_W-1:0] d_mem_idx;
    logic              d_wr_commit;

    logic              err_reg;
    logic [15:0]       wr_cnt_reg;

    mem_lat_channel #(
        .DEPTH    (PROG_DEPTH),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RD_LAT   (RD_LAT),
        .OOR_WORD (NOP_WORD)
    ) u_prog_ch (
        .clk      (CLK),
        .rst_n    (Reset),
        .req      (CS_P),
        .req_en   (!Load_EN),
        .addr     (ADDR_Prog),
        .we       (1'b0),
        .rd_word  (pmem_q),
        .accept   (p_accept),
        .addr_bad (p_addr_bad),
        .mem_idx  (p_mem_idx),
        .bus_word (Prog_BUS_READ),
        .ready    (Ready_P)
    );

    mem_lat_channel #(
        .DEPTH    (DATA_DEPTH),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RD_LAT   (RD_LAT),
        .OOR_WORD (IDLE_WORD)
    ) u_data_ch (
        .clk      (CLK),
        .rst_n    (Reset),
        .req      (CS),
        .req_en   (1'b1),
        .addr     (ADDR),
        .we       (WE),
        .rd_word  (dmem_q),
        .accept   (d_accept),
        .addr_bad (d_addr_bad),
        .mem_idx  (d_mem_idx),
        .bus_word (Data_BUS_READ),
        .ready    (Ready)
    );

    // Program memory: preload write port, registered read port.
    always_ff @(posedge CLK) begin
        if (Load_EN) begin
            pmem[Load_ADDR] <= Load_DATA;
        end
        pmem_q <= pmem[p_mem_idx];
    end

    // Data memory: writes commit at the accepting edge; bad addresses drop.
    assign d_wr_commit = d_accept && WE && !d_addr_bad;

    always_ff @(posedge CLK) begin
        if (d_wr_commit) begin
            dmem[d_mem_idx] <= Data_BUS_WRITE;
        end
        dmem_q <= dmem[d_mem_idx];
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            err_reg    <= 1'b0;
            wr_cnt_reg <= '0;
        end else begin
            if ((p_accept && p_addr_bad) || (d_accept && d_addr_bad)) begin
                err_reg <= 1'b1;
            end
            if (d_wr_commit && (wr_cnt_reg != 16'hFFFF)) begin
                wr_cnt_reg <= wr_cnt_reg + 16'd1;
            end
        end
    end

    assign Addr_Err = err_reg;
    assign Wr_Count = wr_cnt_reg;

endmodule

// File: tb/tb_bus_mem_model.sv
module tb_bus_mem_model;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] ADDR_Prog = '0;
    logic        CS_P = 1'b0;
    logic [31:0] Prog_BUS_READ;
    logic        Ready_P;
    logic [31:0] ADDR = '0;
    logic        CS = 1'b0;
    logic        WE = 1'b0;
    logic [31:0] Data_BUS_WRITE = '0;
    logic [31:0] Data_BUS_READ;
    logic        Ready;
    logic        Load_EN = 1'b0;
    logic [9:0]  Load_ADDR = '0;
    logic [31:0] Load_DATA = '0;
    logic        Addr_Err;
    logic [15:0] Wr_Count;

    int errors = 0;
    int checks = 0;

    bus_mem_model #(
        .RD_LAT (3)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .ADDR_Prog      (ADDR_Prog),
        .CS_P           (CS_P),
        .Prog_BUS_READ  (Prog_BUS_READ),
        .Ready_P        (Ready_P),
        .ADDR           (ADDR),
        .CS             (CS),
        .WE             (WE),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .Data_BUS_READ  (Data_BUS_READ),
        .Ready          (Ready),
        .Load_EN        (Load_EN),
        .Load_ADDR      (Load_ADDR),
        .Load_DATA      (Load_DATA),
        .Addr_Err       (Addr_Err),
        .Wr_Count       (Wr_Count)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one data access; lat = edges from acceptance to Ready, -1 on timeout.
    task automatic data_access(input logic [31:0] a, input logic w,
                               input logic [31:0] wd, output int lat);
        ADDR = a; WE = w; Data_BUS_WRITE = wd; CS = 1'b1;
        tick();
        CS = 1'b0; WE = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (Ready) begin
                lat = i;
                break;
            end
        end
        $display("data %s addr=%h wdata=%h lat=%0d rdata=%h wr_count=%0d err=%b",
                 w ? "WR" : "RD", a, wd, lat, Data_BUS_READ, Wr_Count, Addr_Err);
    endtask

    task automatic fetch(input logic [31:0] a, output int lat);
        ADDR_Prog = a; CS_P = 1'b1;
        tick();
        CS_P = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (Ready_P) begin
                lat = i;
                break;
            end
        end
        $display("fetch addr=%h lat=%0d instr=%h err=%b", a, lat, Prog_BUS_READ, Addr_Err);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #12;
        Reset = 1'b1;
        tick();
        $display("reset released: data=%h prog=%h rdy=%b rdyp=%b err=%b cnt=%0d",
                 Data_BUS_READ, Prog_BUS_READ, Ready, Ready_P, Addr_Err, Wr_Count);
        checks++; if (Data_BUS_READ !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_data got=%h exp=FFFFFFFF", Data_BUS_READ); end
        checks++; if (Prog_BUS_READ !== 32'h0) begin errors++; $display("FAIL reset_prog got=%h exp=00000000", Prog_BUS_READ); end
        checks++; if (Ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", Ready); end
        checks++; if (Ready_P !== 1'b0) begin errors++; $display("FAIL reset_ready_p got=%b exp=0", Ready_P); end
        checks++; if (Addr_Err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", Addr_Err); end
        checks++; if (Wr_Count !== 16'd0) begin errors++; $display("FAIL reset_wr_count got=%0d exp=0", Wr_Count); end
    endtask

    task automatic test_prog_fetch();
        int lat;
        int seen;
        // Preload two words with a fetch request held high: it must be ignored.
        ADDR_Prog = 32'h10; CS_P = 1'b1;
        Load_EN = 1'b1; Load_ADDR = 10'd4; Load_DATA = 32'h2008000A;
        tick();
        Load_ADDR = 10'd5; Load_DATA = 32'h11111111;
        tick();
        Load_EN = 1'b0; CS_P = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (Ready_P) seen++;
            tick();
        end
        $display("preload done, ready_p pulses while loading=%0d", seen);
        checks++; if (seen !== 0) begin errors++; $display("FAIL load_blocks_fetch got=%0d exp=0", seen); end

        fetch(32'h10, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL fetch_latency got=%0d exp=3", lat); end
        checks++; if (Prog_BUS_READ !== 32'h2008000A) begin errors++; $display("FAIL fetch_data got=%h exp=2008000A", Prog_BUS_READ); end
        tick();
        checks++; if (Ready_P !== 1'b0) begin errors++; $display("FAIL ready_p_width got=%b exp=0", Ready_P); end
        checks++; if (Prog_BUS_READ !== 32'h2008000A) begin errors++; $display("FAIL fetch_hold got=%h exp=2008000A", Prog_BUS_READ); end
        fetch(32'h14, lat);
        checks++; if (Prog_BUS_READ !== 32'h11111111) begin errors++; $display("FAIL fetch_word5 got=%h exp=11111111", Prog_BUS_READ); end
    endtask

    task automatic test_write_read();
        int lat;
        data_access(32'h40, 1'b1, 32'hDEADBEEF, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL write_latency got=%0d exp=3", lat); end
        checks++; if (Wr_Count !== 16'd1) begin errors++; $display("FAIL write_count got=%0d exp=1", Wr_Count); end
        checks++; if (Data_BUS_READ !== 32'hFFFFFFFF) begin errors++; $display("FAIL write_no_read_update got=%h exp=FFFFFFFF", Data_BUS_READ); end
        data_access(32'h40, 1'b0, 32'h0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency got=%0d exp=3", lat); end
        checks++; if (Data_BUS_READ !== 32'hDEADBEEF) begin errors++; $display("FAIL read_back_40 got=%h exp=DEADBEEF", Data_BUS_READ); end
        data_access(32'h44, 1'b1, 32'h12345678, lat);
        data_access(32'hFFC, 1'b1, 32'hA5A5C3C3, lat);
        data_access(32'h44, 1'b0, 32'h0, lat);
        checks++; if (Data_BUS_READ !== 32'h12345678) begin errors++; $display("FAIL read_back_44 got=%h exp=12345678", Data_BUS_READ); end
        data_access(32'hFFC, 1'b0, 32'h0, lat);
        checks++; if (Data_BUS_READ !== 32'hA5A5C3C3) begin errors++; $display("FAIL read_back_top got=%h exp=A5A5C3C3", Data_BUS_READ); end
        checks++; if (Wr_Count !== 16'd3) begin errors++; $display("FAIL write_count3 got=%0d exp=3", Wr_Count); end
        checks++; if (Addr_Err !== 1'b0) begin errors++; $display("FAIL no_err_in_range got=%b exp=0", Addr_Err); end
    endtask

    task automatic test_out_of_range();
        int lat;
        data_access(32'h1000, 1'b0, 32'h0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL oor_ready got=%0d exp=3", lat); end
        checks++; if (Data_BUS_READ !== 32'hFFFFFFFF) begin errors++; $display("FAIL oor_data got=%h exp=FFFFFFFF", Data_BUS_READ); end
        checks++; if (Addr_Err !== 1'b1) begin errors++; $display("FAIL oor_err got=%b exp=1", Addr_Err); end
        data_access(32'h42, 1'b1, 32'h55555555, lat);
        checks++; if (Wr_Count !== 16'd3) begin errors++; $display("FAIL misaligned_write_count got=%0d exp=3", Wr_Count); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL misaligned_ready got=%0d exp=3", lat); end
        data_access(32'h40, 1'b0, 32'h0, lat);
        checks++; if (Data_BUS_READ !== 32'hDEADBEEF) begin errors++; $display("FAIL misaligned_dropped got=%h exp=DEADBEEF", Data_BUS_READ); end
        checks++; if (Addr_Err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", Addr_Err); end
        fetch(32'h1000, lat);
        checks++; if (Prog_BUS_READ !== 32'h0) begin errors++; $display("FAIL oor_fetch got=%h exp=00000000", Prog_BUS_READ); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL oor_fetch_ready got=%0d exp=3", lat); end
    endtask

    task automatic test_simultaneous();
        int lat = -1;
        logic both;
        ADDR = 32'h44; WE = 1'b0; CS = 1'b1;
        ADDR_Prog = 32'h10; CS_P = 1'b1;
        tick();
        CS = 1'b0; CS_P = 1'b0;
        both = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (Ready || Ready_P) begin
                lat = i;
                both = Ready && Ready_P;
                break;
            end
        end
        $display("simultaneous lat=%0d ready=%b ready_p=%b data=%h instr=%h",
                 lat, Ready, Ready_P, Data_BUS_READ, Prog_BUS_READ);
        checks++; if (both !== 1'b1) begin errors++; $display("FAIL sim_both_ready got=%b exp=1", both); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL sim_latency got=%0d exp=3", lat); end
        checks++; if (Data_BUS_READ !== 32'h12345678) begin errors++; $display("FAIL sim_data got=%h exp=12345678", Data_BUS_READ); end
        checks++; if (Prog_BUS_READ !== 32'h2008000A) begin errors++; $display("FAIL sim_instr got=%h exp=2008000A", Prog_BUS_READ); end
    endtask

    task automatic test_back_to_back();
        int t1 = -1;
        int t2 = -1;
        ADDR = 32'h40; WE = 1'b0; CS = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (Ready) begin
                if (t1 < 0) begin
                    t1 = i;
                end else begin
                    t2 = i;
                    CS = 1'b0;
                    break;
                end
            end
        end
        CS = 1'b0;
        $display("back_to_back ready at %0d and %0d data=%h", t1, t2, Data_BUS_READ);
        checks++; if (t1 !== 4) begin errors++; $display("FAIL b2b_first got=%0d exp=4", t1); end
        checks++; if (t2 !== 8) begin errors++; $display("FAIL b2b_second got=%0d exp=8", t2); end
        checks++; if (Data_BUS_READ !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_data got=%h exp=DEADBEEF", Data_BUS_READ); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen = 0;
        data_access(32'h80, 1'b1, 32'hCAFEF00D, lat);
        checks++; if (Wr_Count !== 16'd4) begin errors++; $display("FAIL pre_reset_count got=%0d exp=4", Wr_Count); end
        ADDR = 32'h80; WE = 1'b0; CS = 1'b1;
        tick();
        CS = 1'b0;
        tick();
        Reset = 1'b0;
        #1;
        $display("reset mid-read: data=%h prog=%h rdy=%b err=%b cnt=%0d",
                 Data_BUS_READ, Prog_BUS_READ, Ready, Addr_Err, Wr_Count);
        checks++; if (Data_BUS_READ !== 32'hFFFFFFFF) begin errors++; $display("FAIL mid_reset_data got=%h exp=FFFFFFFF", Data_BUS_READ); end
        checks++; if (Prog_BUS_READ !== 32'h0) begin errors++; $display("FAIL mid_reset_prog got=%h exp=00000000", Prog_BUS_READ); end
        checks++; if (Wr_Count !== 16'd0) begin errors++; $display("FAIL mid_reset_count got=%0d exp=0", Wr_Count); end
        checks++; if (Addr_Err !== 1'b0) begin errors++; $display("FAIL mid_reset_err got=%b exp=0", Addr_Err); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Ready) seen++;
        end
        #2;
        Reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (Ready) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL aborted_no_ready got=%0d exp=0", seen); end
        data_access(32'h80, 1'b0, 32'h0, lat);
        checks++; if (Data_BUS_READ !== 32'hCAFEF00D) begin errors++; $display("FAIL survives_reset got=%h exp=CAFEF00D", Data_BUS_READ); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL post_reset_latency got=%0d exp=3", lat); end
    endtask

    initial begin
        test_reset();
        test_prog_fetch();
        test_write_read();
        test_out_of_range();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
